// File: rtl/collision_monitor_pkg.sv
// Shared light-bike definitions: heading codes, winner encoding, screen defaults
// and the monitor FSM state type.
package collision_monitor_pkg;

    localparam logic [2:0] ORIENT_UP    = 3'd0;
    localparam logic [2:0] ORIENT_LEFT  = 3'd1;
    localparam logic [2:0] ORIENT_DOWN  = 3'd2;
    localparam logic [2:0] ORIENT_RIGHT = 3'd3;
    localparam logic [2:0] ORIENT_DEAD  = 3'd5;

    localparam logic [3:0] WINNER_DRAW = 4'hF;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_PROBE_AHEAD = 16;
    localparam int DEF_PROBE_SIDE  = 5;
    localparam int DEF_ADDR_W      = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EVAL,
        ST_OVER
    } state_t;

    function automatic int count_ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/collision_monitor_if.sv
// Scan-side inputs and crash/round results exchanged between the video
// pipeline (master) and the collision monitor (slave).
interface collision_monitor_if #(
    parameter int NUM_BIKES = 2,
    parameter int ADDR_W    = 19
);
    logic                        frame_start;
    logic                        round_start;
    logic                        master_switch;
    logic [ADDR_W-1:0]           addr;
    logic                        addr_valid;
    logic [3:0]                  trail_output;
    logic [NUM_BIKES*ADDR_W-1:0] bike_location;
    logic [NUM_BIKES*3-1:0]      bike_orient;
    logic [NUM_BIKES-1:0]        crashed;
    logic                        crash_pulse;
    logic                        round_over;
    logic [3:0]                  winner;

    modport master (
        output frame_start, round_start, master_switch, addr, addr_valid,
               trail_output, bike_location, bike_orient,
        input  crashed, crash_pulse, round_over, winner
    );

    modport slave (
        input  frame_start, round_start, master_switch, addr, addr_valid,
               trail_output, bike_location, bike_orient,
        output crashed, crash_pulse, round_over, winner
    );
endinterface

// File: rtl/collision_monitor_probe_gen.sv
// Maps one bike's snapshot middle address and heading to its two whisker probe
// addresses, flagging when either probe leaves the screen (no row wrap).
module collision_monitor_probe_gen
    import collision_monitor_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PROBE_AHEAD = DEF_PROBE_AHEAD,
    parameter int PROBE_SIDE  = DEF_PROBE_SIDE,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] location,
    input  logic [2:0]        orient,
    output logic [ADDR_W-1:0] probe_a,
    output logic [ADDR_W-1:0] probe_b,
    output logic              probe_en,
    output logic              out_of_bounds
);
    localparam int SW = ADDR_W + 2;
    localparam logic signed [SW-1:0] C_W          = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] C_AHEAD      = SW'(PROBE_AHEAD);
    localparam logic signed [SW-1:0] C_SIDE       = SW'(PROBE_SIDE);
    localparam logic signed [SW-1:0] C_AHEAD_ROWS = SW'(PROBE_AHEAD * SCREEN_W);
    localparam logic signed [SW-1:0] C_SIDE_ROWS  = SW'(PROBE_SIDE * SCREEN_W);
    localparam logic signed [SW-1:0] C_LIMIT      = SW'(SCREEN_W * SCREEN_H);

    logic signed [SW-1:0] mid, mid_col;
    logic signed [SW-1:0] h_a, h_b, v_a, v_b;
    logic signed [SW-1:0] p_a, p_b, col_a, col_b;
    logic                 bad_a, bad_b;

    // h_* is the column shift, v_* the row shift already scaled to addresses
    always_comb begin
        mid      = SW'(location);
        mid_col  = SW'(location % ADDR_W'(SCREEN_W));
        h_a      = '0;
        h_b      = '0;
        v_a      = '0;
        v_b      = '0;
        probe_en = 1'b1;
        case (orient)
            ORIENT_UP: begin
                h_a = -C_SIDE;   h_b = C_SIDE;
                v_a = -C_AHEAD_ROWS; v_b = -C_AHEAD_ROWS;
            end
            ORIENT_LEFT: begin
                h_a = -C_AHEAD;  h_b = -C_AHEAD;
                v_a = -C_SIDE_ROWS;  v_b = C_SIDE_ROWS;
            end
            ORIENT_DOWN: begin
                h_a = C_SIDE;    h_b = -C_SIDE;
                v_a = C_AHEAD_ROWS;  v_b = C_AHEAD_ROWS;
            end
            ORIENT_RIGHT: begin
                h_a = C_AHEAD;   h_b = C_AHEAD;
                v_a = -C_SIDE_ROWS;  v_b = C_SIDE_ROWS;
            end
            default: probe_en = 1'b0;
        endcase
        p_a   = mid + h_a + v_a;
        p_b   = mid + h_b + v_b;
        col_a = mid_col + h_a;
        col_b = mid_col + h_b;
        bad_a = p_a[SW-1] | (p_a >= C_LIMIT) | col_a[SW-1] | (col_a >= C_W);
        bad_b = p_b[SW-1] | (p_b >= C_LIMIT) | col_b[SW-1] | (col_b >= C_W);
        out_of_bounds = probe_en & (bad_a | bad_b);
        probe_a = p_a[ADDR_W-1:0];
        probe_b = p_b[ADDR_W-1:0];
    end

endmodule

// File: rtl/collision_monitor.sv
// Multi-bike collision monitor: per-pixel whisker hits accumulated over a frame,
// committed at the frame boundary together with wall and dead-bike terms.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | round armed, waiting for first frame_start (takes snapshot)
// SCAN    | frame in progress, accumulating probe hits per bike
// EVAL    | one cycle: commit crashes, decide winner / round end
// OVER    | round finished, outputs held until round_start
module collision_monitor
    import collision_monitor_pkg::*;
#(
    parameter int NUM_BIKES   = 2,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PROBE_AHEAD = DEF_PROBE_AHEAD,
    parameter int PROBE_SIDE  = DEF_PROBE_SIDE,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input logic          clock,
    input logic          resetn,
    collision_monitor_if.slave bus
);
    state_t state, state_d;

    logic [NUM_BIKES-1:0][ADDR_W-1:0] snap_loc;
    logic [NUM_BIKES-1:0][2:0]        snap_orient;
    logic                             snap_en;

    logic [NUM_BIKES-1:0] hit, hit_d;
    logic [NUM_BIKES-1:0] crashed, crashed_d;
    logic [NUM_BIKES-1:0] new_crash;
    logic                 crash_pulse, pulse_d;
    logic                 round_over, over_d;
    logic [3:0]           winner, winner_d, sole;
    int                   alive;

    logic [ADDR_W-1:0]    probe_a [NUM_BIKES];
    logic [ADDR_W-1:0]    probe_b [NUM_BIKES];
    logic [NUM_BIKES-1:0] probe_en, oob, is_dead, scan_hit, wall_hit;

    for (genvar g = 0; g < NUM_BIKES; g++) begin : g_bike
        collision_monitor_probe_gen #(
            .SCREEN_W    (SCREEN_W),
            .SCREEN_H    (SCREEN_H),
            .PROBE_AHEAD (PROBE_AHEAD),
            .PROBE_SIDE  (PROBE_SIDE),
            .ADDR_W      (ADDR_W)
        ) u_probe (
            .location      (snap_loc[g]),
            .orient        (snap_orient[g]),
            .probe_a       (probe_a[g]),
            .probe_b       (probe_b[g]),
            .probe_en      (probe_en[g]),
            .out_of_bounds (oob[g])
        );

        assign is_dead[g]  = (snap_orient[g] == ORIENT_DEAD);
        // an off-screen probe address is meaningless, so it never matches
        assign scan_hit[g] = bus.addr_valid & bus.master_switch & (bus.trail_output != 4'd0)
                           & probe_en[g] & ~oob[g] & ~crashed[g]
                           & ((bus.addr == probe_a[g]) | (bus.addr == probe_b[g]));
        assign wall_hit[g] = bus.master_switch & ~crashed[g] & (oob[g] | is_dead[g]);
    end

    always_comb begin
        state_d   = state;
        hit_d     = hit;
        crashed_d = crashed;
        pulse_d   = 1'b0;
        over_d    = round_over;
        winner_d  = winner;
        snap_en   = 1'b0;
        new_crash = '0;
        alive     = 0;
        sole      = '0;
        case (state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    snap_en = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                hit_d = hit | scan_hit;
                // wall/dead terms belong to the closing frame's snapshot, so fold them in before it is replaced
                if (bus.frame_start) begin
                    hit_d   = hit | scan_hit | wall_hit;
                    snap_en = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                new_crash = hit & ~crashed;
                crashed_d = crashed | new_crash;
                pulse_d   = |new_crash;
                hit_d     = '0;
                alive     = NUM_BIKES - count_ones(8'(crashed_d));
                for (int i = NUM_BIKES - 1; i >= 0; i--) begin
                    if (!crashed_d[i]) sole = 4'(i);
                end
                if (alive == 1) begin
                    winner_d = sole;
                    over_d   = 1'b1;
                    state_d  = ST_OVER;
                end else if (alive == 0) begin
                    winner_d = WINNER_DRAW;
                    over_d   = 1'b1;
                    state_d  = ST_OVER;
                end else begin
                    state_d  = ST_SCAN;
                end
            end
            default: ;
        endcase
        if (bus.round_start) begin
            state_d   = ST_IDLE;
            hit_d     = '0;
            crashed_d = '0;
            pulse_d   = 1'b0;
            over_d    = 1'b0;
            winner_d  = '0;
            snap_en   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            hit         <= '0;
            crashed     <= '0;
            crash_pulse <= 1'b0;
            round_over  <= 1'b0;
            winner      <= '0;
            snap_loc    <= '0;
            snap_orient <= '0;
        end else begin
            state       <= state_d;
            hit         <= hit_d;
            crashed     <= crashed_d;
            crash_pulse <= pulse_d;
            round_over  <= over_d;
            winner      <= winner_d;
            if (snap_en) begin
                for (int i = 0; i < NUM_BIKES; i++) begin
                    snap_loc[i]    <= bus.bike_location[i*ADDR_W +: ADDR_W];
                    snap_orient[i] <= bus.bike_orient[i*3 +: 3];
                end
            end
        end
    end

    assign bus.crashed     = crashed;
    assign bus.crash_pulse = crash_pulse;
    assign bus.round_over  = round_over;
    assign bus.winner      = winner;

endmodule

// File: tb/tb_collision_monitor.sv
// Bench for collision_monitor: directed round scenarios plus randomized rounds,
// all outputs compared every cycle against a row/column reference model.
module tb_collision_monitor;
    localparam int NB = 2;
    localparam int AW = 19;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int A  = 16;
    localparam int S  = 5;

    localparam int PH_IDLE = 0;
    localparam int PH_SCAN = 1;
    localparam int PH_EVAL = 2;
    localparam int PH_OVER = 3;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    collision_monitor_if #(.NUM_BIKES(NB), .ADDR_W(AW)) bus();

    collision_monitor #(
        .NUM_BIKES(NB), .SCREEN_W(W), .SCREEN_H(H),
        .PROBE_AHEAD(A), .PROBE_SIDE(S), .ADDR_W(AW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit m_crashed [NB];
    bit m_hit     [NB];
    int m_snap_loc[NB];
    int m_snap_ori[NB];
    int m_phase;
    bit m_over;
    bit m_pulse;
    int m_winner;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // probes in screen coordinates: (row, col) of the middle shifted along/across the heading
    function automatic void model_probes(input int loc, input int ori, output int pa, output int pb,
                                         output bit has, output bit out);
        int row, col, dr0, dc0, dr1, dc1;
        row = loc / W;
        col = loc % W;
        dr0 = 0; dc0 = 0; dr1 = 0; dc1 = 0;
        has = 1'b1;
        case (ori)
            0: begin dr0 = -A; dc0 = -S; dr1 = -A; dc1 =  S; end
            1: begin dr0 = -S; dc0 = -A; dr1 =  S; dc1 = -A; end
            2: begin dr0 =  A; dc0 =  S; dr1 =  A; dc1 = -S; end
            3: begin dr0 = -S; dc0 =  A; dr1 =  S; dc1 =  A; end
            default: has = 1'b0;
        endcase
        out = has && ((row + dr0 < 0) || (row + dr0 >= H) || (col + dc0 < 0) || (col + dc0 >= W) ||
                      (row + dr1 < 0) || (row + dr1 >= H) || (col + dc1 < 0) || (col + dc1 >= W));
        pa = (row + dr0) * W + col + dc0;
        pb = (row + dr1) * W + col + dc1;
    endfunction

    function automatic void model_clear(input bit full);
        for (int i = 0; i < NB; i++) begin
            m_crashed[i] = 1'b0;
            m_hit[i]     = 1'b0;
            if (full) begin
                m_snap_loc[i] = 0;
                m_snap_ori[i] = 0;
            end
        end
        m_phase  = PH_IDLE;
        m_over   = 1'b0;
        m_pulse  = 1'b0;
        m_winner = 0;
    endfunction

    function automatic logic [31:0] exp_crashed();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i] = m_crashed[i];
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".crashed"},     32'(bus.crashed),     exp_crashed());
        check_val({tag, ".crash_pulse"}, 32'(bus.crash_pulse), 32'(m_pulse));
        check_val({tag, ".round_over"},  32'(bus.round_over),  32'(m_over));
        check_val({tag, ".winner"},      32'(bus.winner),      32'(m_winner));
    endtask

    task automatic tick();
        bit fs, rs, ms, vld, rn;
        int ad, tr, alive, pa, pb;
        bit has, out;
        int cur_loc[NB];
        int cur_ori[NB];
        fs  = bus.frame_start;
        rs  = bus.round_start;
        ms  = bus.master_switch;
        vld = bus.addr_valid;
        rn  = resetn;
        ad  = int'(bus.addr);
        tr  = int'(bus.trail_output);
        for (int i = 0; i < NB; i++) begin
            cur_loc[i] = int'(bus.bike_location[i*AW +: AW]);
            cur_ori[i] = int'(bus.bike_orient[i*3 +: 3]);
        end
        @(posedge clock);
        #1;
        cyc++;
        m_pulse = 1'b0;
        if (!rn) begin
            model_clear(1'b1);
        end else if (rs) begin
            model_clear(1'b0);
        end else if (m_phase == PH_IDLE) begin
            if (fs) begin
                for (int i = 0; i < NB; i++) begin
                    m_snap_loc[i] = cur_loc[i];
                    m_snap_ori[i] = cur_ori[i];
                end
                m_phase = PH_SCAN;
            end
        end else if (m_phase == PH_SCAN) begin
            for (int i = 0; i < NB; i++) begin
                model_probes(m_snap_loc[i], m_snap_ori[i], pa, pb, has, out);
                if (vld && ms && tr != 0 && !m_crashed[i] && has && !out && (ad == pa || ad == pb))
                    m_hit[i] = 1'b1;
                if (fs && ms && !m_crashed[i] && (out || m_snap_ori[i] == 5))
                    m_hit[i] = 1'b1;
            end
            if (fs) begin
                for (int i = 0; i < NB; i++) begin
                    m_snap_loc[i] = cur_loc[i];
                    m_snap_ori[i] = cur_ori[i];
                end
                m_phase = PH_EVAL;
            end
        end else if (m_phase == PH_EVAL) begin
            alive = 0;
            for (int i = 0; i < NB; i++) begin
                if (m_hit[i] && !m_crashed[i]) begin
                    m_crashed[i] = 1'b1;
                    m_pulse      = 1'b1;
                end
                m_hit[i] = 1'b0;
                if (!m_crashed[i]) alive++;
            end
            if (alive <= 1) begin
                m_over   = 1'b1;
                m_phase  = PH_OVER;
                m_winner = 15;
                for (int i = NB - 1; i >= 0; i--) if (!m_crashed[i]) m_winner = i;
            end else begin
                m_phase = PH_SCAN;
            end
        end
        check_outputs("cyc");
    endtask

    task automatic set_bike(input int i, input int loc, input int ori);
        bus.bike_location[i*AW +: AW] = AW'(loc);
        bus.bike_orient[i*3 +: 3]     = 3'(ori);
    endtask

    task automatic rand_bike(input int i);
        int r, ori;
        r = int'($urandom_range(0, 19));
        if (r < 16)      ori = r % 4;
        else if (r < 18) ori = 5;
        else if (r == 18) ori = 4;
        else             ori = 6 + int'($urandom_range(0, 1));
        set_bike(i, int'($urandom_range(0, H - 1)) * W + int'($urandom_range(0, W - 1)), ori);
    endtask

    task automatic frame_edge();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic pixel(input int ad, input int tr);
        bus.addr         = AW'(ad);
        bus.trail_output = 4'(tr);
        bus.addr_valid   = 1'b1;
        tick();
        bus.addr_valid   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic new_round(input string tag);
        bus.round_start = 1'b1;
        tick();
        bus.round_start = 1'b0;
        check_val({tag, ".rs_crashed"}, 32'(bus.crashed),    32'h0);
        check_val({tag, ".rs_over"},    32'(bus.round_over), 32'h0);
        check_val({tag, ".rs_winner"},  32'(bus.winner),     32'h0);
    endtask

    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        model_clear(1'b1);
        check_outputs(tag);
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic drive_rand_pixel();
        int b, pa, pb;
        bit has, out;
        bus.addr_valid   = ($urandom_range(0, 6) != 0);
        bus.trail_output = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        b = int'($urandom_range(0, NB - 1));
        model_probes(m_snap_loc[b], m_snap_ori[b], pa, pb, has, out);
        if (has && !out && $urandom_range(0, 9) < 4)
            bus.addr = AW'(($urandom_range(0, 1) != 0) ? pa : pb);
        else
            bus.addr = AW'($urandom_range(0, W * H - 1));
    endtask

    initial begin
        resetn            = 1'b0;
        bus.frame_start   = 1'b0;
        bus.round_start   = 1'b0;
        bus.master_switch = 1'b1;
        bus.addr          = '0;
        bus.addr_valid    = 1'b0;
        bus.trail_output  = '0;
        bus.bike_location = '0;
        bus.bike_orient   = '0;
        model_clear(1'b1);
        idle_cycles(2);
        check_val("reset.crashed", 32'(bus.crashed), 32'h0);
        check_val("reset.winner",  32'(bus.winner),  32'h0);
        resetn = 1'b1;
        tick();

        // bike0 runs into a trail pixel under its left whisker
        set_bike(0, 100 * W + 320, 0);
        set_bike(1, 240 * W + 320, 3);
        frame_edge();
        pixel(84 * W + 315, 3);
        idle_cycles(2);
        frame_edge();
        tick();
        check_val("s1.crashed", 32'(bus.crashed),     32'h1);
        check_val("s1.pulse",   32'(bus.crash_pulse), 32'h1);
        check_val("s1.over",    32'(bus.round_over),  32'h1);
        check_val("s1.winner",  32'(bus.winner),      32'h1);
        tick();
        check_val("s1.pulse_end", 32'(bus.crash_pulse), 32'h0);

        // bike1 near the top edge heading up: whiskers at row -6
        new_round("s2");
        set_bike(0, 240 * W + 320, 3);
        set_bike(1, 10 * W + 200, 0);
        frame_edge();
        idle_cycles(5);
        frame_edge();
        tick();
        check_val("s2.crashed", 32'(bus.crashed), 32'h2);
        check_val("s2.winner",  32'(bus.winner),  32'h0);
        check_val("s2.over",    32'(bus.round_over), 32'h1);

        // both bikes hit in the same frame: draw
        new_round("s3");
        set_bike(0, 100 * W + 320, 0);
        set_bike(1, 300 * W + 100, 2);
        frame_edge();
        pixel(84 * W + 315, 1);
        pixel(316 * W + 105, 9);
        frame_edge();
        tick();
        check_val("s3.crashed", 32'(bus.crashed), 32'h3);
        check_val("s3.winner",  32'(bus.winner),  32'hF);

        // detection disabled, then enabled with bike1 marked dead
        new_round("s4");
        bus.master_switch = 1'b0;
        set_bike(0, 100 * W + 320, 0);
        set_bike(1, 240 * W + 320, 5);
        frame_edge();
        pixel(84 * W + 315, 3);
        frame_edge();
        tick();
        check_val("s4.crashed", 32'(bus.crashed),     32'h0);
        check_val("s4.pulse",   32'(bus.crash_pulse), 32'h0);
        check_val("s4.over",    32'(bus.round_over),  32'h0);
        bus.master_switch = 1'b1;
        idle_cycles(2);
        frame_edge();
        tick();
        check_val("s4.dead_crashed", 32'(bus.crashed), 32'h2);
        check_val("s4.dead_winner",  32'(bus.winner),  32'h0);

        // location moved mid-frame: only the next snapshot sees it
        new_round("s5");
        set_bike(0, 200 * W + 320, 0);
        set_bike(1, 400 * W + 320, 1);
        frame_edge();
        set_bike(0, 100 * W + 320, 0);
        pixel(84 * W + 315, 3);
        frame_edge();
        tick();
        check_val("s5.no_crash", 32'(bus.crashed), 32'h0);
        pixel(84 * W + 315, 3);
        frame_edge();
        tick();
        check_val("s5.crashed", 32'(bus.crashed), 32'h1);
        check_val("s5.winner",  32'(bus.winner),  32'h1);

        // async reset from OVER, then mid-SCAN with a pending hit
        async_reset("s6.rst_over");
        frame_edge();
        pixel(84 * W + 315, 3);
        async_reset("s6.rst_scan");
        frame_edge();
        idle_cycles(3);
        frame_edge();
        tick();
        check_val("s6.crashed", 32'(bus.crashed), 32'h0);
        check_val("s6.over",    32'(bus.round_over), 32'h0);

        for (int r = 0; r < 40; r++) begin
            bus.round_start = 1'b1;
            if ($urandom_range(0, 3) == 0) bus.frame_start = 1'b1;
            tick();
            bus.round_start = 1'b0;
            bus.frame_start = 1'b0;
            for (int i = 0; i < NB; i++) rand_bike(i);
            bus.master_switch = ($urandom_range(0, 7) != 0);
            frame_edge();
            for (int f = 0; f < 6 && m_phase != PH_OVER; f++) begin
                int n;
                n = int'($urandom_range(4, 24));
                for (int p = 0; p < n; p++) begin
                    if ($urandom_range(0, 9) == 0) rand_bike(int'($urandom_range(0, NB - 1)));
                    if ($urandom_range(0, 9) == 0) bus.master_switch = ~bus.master_switch;
                    if ($urandom_range(0, 59) == 0) bus.round_start = 1'b1;
                    drive_rand_pixel();
                    tick();
                    bus.round_start = 1'b0;
                    bus.addr_valid  = 1'b0;
                end
                drive_rand_pixel();
                frame_edge();
                bus.addr_valid = 1'b0;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
